// File: rtl/mc_maindec.sv
// mc_maindec: multicycle main control FSM for the MIPS core.
//
// This block decodes the opcode held in the instruction register. It then
// sequences one instruction over 3 to 5 cycles. All outputs are Moore outputs:
// each one depends only on the current state, so there is no combinational
// path from op to any output.
//
// Ports
//   clk       in  1  system clock, rising edge
//   reset     in  1  asynchronous active-high reset, forces FETCH
//   op        in  6  opcode instr[31:26]; sampled in DECODE and MEMADR only
//   iord      out 1  memory address select (0 = PC, 1 = ALUOut)
//   memwrite  out 1  data memory write enable
//   irwrite   out 1  instruction register write enable
//   pcwrite   out 1  unconditional PC write
//   branch    out 1  conditional PC write (qualified by zero in datapath)
//   pcsrc     out 2  00 ALU result, 01 ALUOut, 10 jump target
//   alusrca   out 1  0 = PC, 1 = register A
//   alusrcb   out 2  00 B, 01 const 4, 10 ext imm, 11 ext imm << 2
//   zeroext   out 1  1 = zero-extend immediate, 0 = sign-extend
//   aluop     out 3  000 add, 001 sub, 010 funct, 011 and, 100 or
//   regdst    out 1  1 = rd, 0 = rt
//   memtoreg  out 1  1 = memory data, 0 = ALUOut
//   regwrite  out 1  register file write enable
//   illegal   out 1  trap flag (HALT state)
//   state     out 4  current state code, for debug
//
// Build option
//   MC_ILLEGAL_TRAP_EN  When defined, an unknown opcode traps into HALT.
//                       HALT is left only by reset. When undefined, an
//                       unknown opcode acts as a 2-cycle NOP, and illegal
//                       is tied 0.

module mc_maindec (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [2:0] aluop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        IWB     = 4'd10,
        JEX     = 4'd11,
        ANDIEX  = 4'd12,
        ORIEX   = 4'd13,
        HALT    = 4'd14
    } state_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_ANDI  = 6'b001100,
        OP_ORI   = 6'b001101,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    state_t cur, nxt;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cur <= FETCH;
        else
            cur <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = RTYPEEX;
                    OP_BEQ:       nxt = BEQEX;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_ANDI:      nxt = ANDIEX;
                    OP_ORI:       nxt = ORIEX;
                    OP_J:         nxt = JEX;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      nxt = HALT;
`else
                    default:      nxt = FETCH;
`endif
                endcase
            end
            // Only lw and sw reach MEMADR, so one opcode compare is enough.
            MEMADR:  nxt = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   nxt = MEMWB;
            RTYPEEX: nxt = RTYPEWB;
            ADDIEX,
            ANDIEX,
            ORIEX:   nxt = IWB;
`ifdef MC_ILLEGAL_TRAP_EN
            HALT:    nxt = HALT;
`else
            HALT:    nxt = FETCH;
`endif
            // MEMWB, MEMWR, RTYPEWB, BEQEX, IWB, JEX and the unused code 15
            default: nxt = FETCH;
        endcase
    end

    // Moore output decode
    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        pcsrc    = 2'b00;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        zeroext  = 1'b0;
        aluop    = 3'b000;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        case (cur)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            DECODE: begin
                alusrcb = 2'b11;
            end
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 3'b010;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 3'b001;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ANDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 3'b011;
                zeroext = 1'b1;
            end
            ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 3'b100;
                zeroext = 1'b1;
            end
            IWB: begin
                regwrite = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;  // HALT and code 15: every enable stays low
        endcase
    end

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal = (cur == HALT);
`else
    assign illegal = 1'b0;
`endif

    assign state = cur;

endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: self-checking bench for mc_maindec.
//
// A reference model predicts the state sequence of each instruction from its
// opcode. It also predicts each control output, using the set of states in
// which that output is asserted. The bench checks the model against the DUT
// on every falling edge. Directed instructions add literal checks on the
// traces and on the control pulses.

module tb_mc_maindec;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       iord, memwrite, irwrite, pcwrite, branch;
    logic [1:0] pcsrc, alusrcb;
    logic       alusrca, zeroext, regdst, memtoreg, regwrite, illegal;
    logic [2:0] aluop;
    logic [3:0] state;

    mc_maindec dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .iord     (iord),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .pcwrite  (pcwrite),
        .branch   (branch),
        .pcsrc    (pcsrc),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .zeroext  (zeroext),
        .aluop    (aluop),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .illegal  (illegal),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Bit order: {iord, memwrite, irwrite, pcwrite, branch, pcsrc[1:0], alusrca,
    //             alusrcb[1:0], zeroext, aluop[2:0], regdst, memtoreg, regwrite, illegal}
    function automatic logic [17:0] exp_outs(input int s);
        logic       e_iord, e_mw, e_irw, e_pcw, e_br, e_asa, e_zx, e_rd, e_m2r, e_rw, e_ill;
        logic [1:0] e_pcsrc, e_asb;
        logic [2:0] e_aluop;
        e_iord  = s inside {3, 5};
        e_mw    = (s == 5);
        e_irw   = (s == 0);
        e_pcw   = s inside {0, 11};
        e_br    = (s == 8);
        e_pcsrc = (s == 8) ? 2'd1 : (s == 11) ? 2'd2 : 2'd0;
        e_asa   = s inside {2, 6, 8, 9, 12, 13};
        e_asb   = (s == 0) ? 2'd1 : (s == 1) ? 2'd3 : (s inside {2, 9, 12, 13}) ? 2'd2 : 2'd0;
        e_zx    = s inside {12, 13};
        e_aluop = (s == 6) ? 3'd2 : (s == 8) ? 3'd1 : (s == 12) ? 3'd3 : (s == 13) ? 3'd4 : 3'd0;
        e_rd    = (s == 7);
        e_m2r   = (s == 4);
        e_rw    = s inside {4, 7, 10};
        e_ill   = TRAP && (s == 14);
        return {e_iord, e_mw, e_irw, e_pcw, e_br, e_pcsrc, e_asa, e_asb, e_zx,
                e_aluop, e_rd, e_m2r, e_rw, e_ill};
    endfunction

    // Reference model: FETCH then DECODE, then the opcode's remaining path
    int mstate = 0;
    int q[$];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mstate = 0;
            q.delete();
        end else if (mstate == 0) begin
            mstate = 1;
        end else if (mstate == 1) begin
            case (op)
                6'h23:   q = '{2, 3, 4};
                6'h2B:   q = '{2, 5};
                6'h00:   q = '{6, 7};
                6'h04:   q = '{8};
                6'h08:   q = '{9, 10};
                6'h0C:   q = '{12, 10};
                6'h0D:   q = '{13, 10};
                6'h02:   q = '{11};
                default: if (TRAP) q = '{14}; else q.delete();
            endcase
            mstate = (q.size() > 0) ? q.pop_front() : 0;
        end else if (q.size() > 0) begin
            mstate = q.pop_front();
        end else if (mstate != 14) begin
            mstate = 0;
        end
    end

    // Per-cycle compare plus per-instruction observations
    logic       cmp_en = 1'b0;
    logic [3:0] trace[$];
    int         iord_cnt, mw_cnt, rw_cnt, m2r_cnt, zx_cnt, rd_cnt, br_cnt, ill_cnt;
    logic [2:0] ex_aluop;
    logic [1:0] ex_pcsrc;
    logic       ex_pcwrite;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state", {44'd0, state}, 48'(mstate));
            chk("outs", {30'd0, iord, memwrite, irwrite, pcwrite, branch, pcsrc, alusrca,
                         alusrcb, zeroext, aluop, regdst, memtoreg, regwrite, illegal},
                {30'd0, exp_outs(mstate)});
            trace.push_back(state);
            if (iord)     iord_cnt++;
            if (memwrite) mw_cnt++;
            if (regwrite) rw_cnt++;
            if (memtoreg) m2r_cnt++;
            if (zeroext)  zx_cnt++;
            if (regdst)   rd_cnt++;
            if (branch)   br_cnt++;
            if (illegal)  ill_cnt++;
            if (state inside {4'd6, 4'd8, 4'd9, 4'd11, 4'd12, 4'd13}) begin
                ex_aluop   = aluop;
                ex_pcsrc   = pcsrc;
                ex_pcwrite = pcwrite;
            end
        end
    end

    // Entered and left at negedge + 1
    task automatic run_instr(input logic [5:0] o, input int n);
        op = o;
        trace.delete();
        iord_cnt = 0; mw_cnt = 0; rw_cnt = 0; m2r_cnt = 0;
        zx_cnt = 0; rd_cnt = 0; br_cnt = 0; ill_cnt = 0;
        ex_aluop = 3'd7; ex_pcsrc = 2'd3; ex_pcwrite = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_trace(input string name, input logic [47:0] exp);
        logic [47:0] got;
        got = '0;
        foreach (trace[i]) got = (got << 4) | 48'(trace[i]);
        chk(name, got, exp);
    endtask

    initial begin
        op    = 6'h00;
        reset = 1'b0;
        #2 reset = 1'b1;   // asynchronous assert between clock edges
        #1;
        chk("rst_state",   {44'd0, state}, 48'd0);
        chk("rst_irwrite", {47'd0, irwrite}, 48'd1);
        chk("rst_pcwrite", {47'd0, pcwrite}, 48'd1);
        chk("rst_outs", {30'd0, iord, memwrite, irwrite, pcwrite, branch, pcsrc, alusrca,
                         alusrcb, zeroext, aluop, regdst, memtoreg, regwrite, illegal},
            48'h0C100);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;

        // lw
        run_instr(6'h23, 5);
        check_trace("lw_trace", 48'h12340);
        chk("lw_iord", 48'(iord_cnt), 48'd1);
        chk("lw_regwrite", 48'(rw_cnt), 48'd1);
        chk("lw_memtoreg", 48'(m2r_cnt), 48'd1);

        // sw
        run_instr(6'h2B, 4);
        check_trace("sw_trace", 48'h1250);
        chk("sw_memwrite", 48'(mw_cnt), 48'd1);
        chk("sw_regwrite", 48'(rw_cnt), 48'd0);

        // j
        run_instr(6'h02, 3);
        check_trace("j_trace", 48'h1B0);
        chk("j_pcsrc", {46'd0, ex_pcsrc}, 48'd2);
        chk("j_pcwrite", {47'd0, ex_pcwrite}, 48'd1);

        // R-type
        run_instr(6'h00, 4);
        check_trace("r_trace", 48'h1670);
        chk("r_aluop", {45'd0, ex_aluop}, 48'd2);
        chk("r_zeroext", 48'(zx_cnt), 48'd0);
        chk("r_regdst", 48'(rd_cnt), 48'd1);

        // andi
        run_instr(6'h0C, 4);
        check_trace("andi_trace", 48'h1CA0);
        chk("andi_aluop", {45'd0, ex_aluop}, 48'd3);
        chk("andi_zeroext", 48'(zx_cnt), 48'd1);
        chk("andi_regdst", 48'(rd_cnt), 48'd0);

        // ori
        run_instr(6'h0D, 4);
        check_trace("ori_trace", 48'h1DA0);
        chk("ori_aluop", {45'd0, ex_aluop}, 48'd4);
        chk("ori_zeroext", 48'(zx_cnt), 48'd1);

        // addi
        run_instr(6'h08, 4);
        check_trace("addi_trace", 48'h19A0);
        chk("addi_zeroext", 48'(zx_cnt), 48'd0);

        // beq
        run_instr(6'h04, 3);
        check_trace("beq_trace", 48'h180);
        chk("beq_branch", 48'(br_cnt), 48'd1);
        chk("beq_aluop", {45'd0, ex_aluop}, 48'd1);
        chk("beq_pcsrc", {46'd0, ex_pcsrc}, 48'd1);

        // Reset during MEMWB of lw: the register write must drop at once
        run_instr(6'h23, 3);
        check_trace("lwabort_trace", 48'h123);
        @(posedge clk);
        #1;
        chk("abort_pre_regwrite", {47'd0, regwrite}, 48'd1);
        #1 reset = 1'b1;
        #1;
        chk("abort_state", {44'd0, state}, 48'd0);
        chk("abort_regwrite", {47'd0, regwrite}, 48'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Unknown opcode
`ifdef MC_ILLEGAL_TRAP_EN
        run_instr(6'h3F, 11);
        check_trace("ill_trace", 48'h1EEEEEEEEEE);
        chk("ill_cnt", 48'(ill_cnt), 48'd10);
        chk("ill_writes", 48'(rw_cnt + mw_cnt), 48'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ill_rst_state", {44'd0, state}, 48'd0);
        chk("ill_rst_illegal", {47'd0, illegal}, 48'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
`else
        run_instr(6'h3F, 2);
        check_trace("ill_trace", 48'h10);
        chk("ill_cnt", 48'(ill_cnt), 48'd0);
`endif

        // Normal operation after the unknown opcode
        run_instr(6'h00, 4);
        check_trace("post_r_trace", 48'h1670);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
